seg_display_mux: RTL and testbench

// Time-multiplexed driver for NUM_DIGITS common-anode hex seven-segment digits.

---
 rtl/seg_display_mux_if.sv | 26 ++
 rtl/seg_display_mux.sv | 157 +++++++++++++++
 tb/tb_seg_display_mux.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/seg_display_mux_if.sv
// Bundles the application-side controls and the display-pin outputs of
// seg_display_mux. The master drives values/controls, the slave (the
// display driver) returns segment, anode and status signals.
interface seg_display_mux_if #(
  parameter int NUM_DIGITS = 4
);
  logic [4*NUM_DIGITS-1:0] valueIn;
  logic [NUM_DIGITS-1:0]   dpIn;
  logic                    loadIn;
  logic                    blankIn;
  logic [6:0]              segOut;
  logic                    dpOut;
  logic [NUM_DIGITS-1:0]   anodeOut;
  logic                    frameOut;
  logic                    pendingOut;

  modport master (
    output valueIn, dpIn, loadIn, blankIn,
    input  segOut, dpOut, anodeOut, frameOut, pendingOut
  );

  modport slave (
    input  valueIn, dpIn, loadIn, blankIn,
    output segOut, dpOut, anodeOut, frameOut, pendingOut
  );
endinterface

// File: rtl/seg_display_mux.sv
// Time-multiplexed common-anode hex seven-segment driver.
// One digit is scanned per slot of TICK_DIV clocks. New values are staged
// on load and only committed to the display register when the scan wraps
// to digit 0, so a frame never shows a mix of old and new digits.
// All pin outputs are registered and lag the index/display state by one cycle.
module seg_display_mux #(
  parameter int NUM_DIGITS       = 4,
  parameter int TICK_DIV         = 50000,
  parameter int LEAD_ZERO_BLANK  = 0,
  parameter int ANODE_ACTIVE_LOW = 1
) (
  input  logic              clkIn,
  input  logic              rstNIn,
  seg_display_mux_if.slave  bus
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int DIV_W = $clog2(TICK_DIV);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);
  localparam logic [DIV_W-1:0] LAST_DIV = DIV_W'(TICK_DIV - 1);
  // Anode pattern with no digit selected.
  localparam logic [NUM_DIGITS-1:0] ANODE_IDLE = {NUM_DIGITS{ANODE_ACTIVE_LOW != 0}};

  // Hex nibble to {G..A}, 1 = segment off.
  function automatic logic [6:0] decode7(input logic [3:0] nib);
    case (nib)
      4'h0: decode7 = 7'h40;
      4'h1: decode7 = 7'h79;
      4'h2: decode7 = 7'h24;
      4'h3: decode7 = 7'h30;
      4'h4: decode7 = 7'h19;
      4'h5: decode7 = 7'h12;
      4'h6: decode7 = 7'h02;
      4'h7: decode7 = 7'h78;
      4'h8: decode7 = 7'h00;
      4'h9: decode7 = 7'h10;
      4'hA: decode7 = 7'h08;
      4'hB: decode7 = 7'h03;
      4'hC: decode7 = 7'h46;
      4'hD: decode7 = 7'h21;
      4'hE: decode7 = 7'h06;
      default: decode7 = 7'h0E;
    endcase
  endfunction

  logic [DIV_W-1:0]        div_reg;
  logic [IDX_W-1:0]        idx_reg;
  logic                    tick;
  logic                    wrap;

  logic [4*NUM_DIGITS-1:0] stage_value_reg;
  logic [NUM_DIGITS-1:0]   stage_dp_reg;
  logic                    pending_reg;
  logic [4*NUM_DIGITS-1:0] disp_value_reg;
  logic [NUM_DIGITS-1:0]   disp_dp_reg;

  logic [6:0]              seg_reg, seg_next;
  logic                    dp_reg, dp_next;
  logic [NUM_DIGITS-1:0]   anode_reg, anode_next;
  logic                    frame_reg;

  assign tick = (div_reg == LAST_DIV);
  assign wrap = tick && (idx_reg == LAST_IDX);

  // Slot divider and digit index; the index only ever takes 0..NUM_DIGITS-1.
  always_ff @(posedge clkIn or negedge rstNIn) begin
    if (!rstNIn) begin
      div_reg <= '0;
      idx_reg <= '0;
    end else begin
      div_reg <= tick ? '0 : div_reg + 1'b1;
      if (tick) begin
        idx_reg <= (idx_reg == LAST_IDX) ? '0 : idx_reg + 1'b1;
      end
    end
  end

  // Staging/display double buffer: newest load wins, commit only on wrap.
  // A load coinciding with the wrap lands in staging and waits a full frame.
  always_ff @(posedge clkIn or negedge rstNIn) begin
    if (!rstNIn) begin
      stage_value_reg <= '0;
      stage_dp_reg    <= '0;
      pending_reg     <= 1'b0;
      disp_value_reg  <= '0;
      disp_dp_reg     <= '0;
    end else begin
      if (wrap && pending_reg) begin
        disp_value_reg <= stage_value_reg;
        disp_dp_reg    <= stage_dp_reg;
      end
      if (bus.loadIn) begin
        stage_value_reg <= bus.valueIn;
        stage_dp_reg    <= bus.dpIn;
        pending_reg     <= 1'b1;
      end else if (wrap) begin
        pending_reg <= 1'b0;
      end
    end
  end

  // Per-digit segment patterns, including leading-zero suppression.
  // upper_zero[i] is set when digit i and every digit above it are zero.
  logic [NUM_DIGITS:0]   upper_zero;
  logic [NUM_DIGITS-1:0] blank_digit;
  logic [NUM_DIGITS-1:0] onehot;
  logic [6:0]            digit_seg [NUM_DIGITS];

  assign upper_zero[NUM_DIGITS] = 1'b1;

  generate
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      assign upper_zero[gi] = upper_zero[gi+1] && (disp_value_reg[4*gi +: 4] == 4'd0);
      if (gi == 0 || LEAD_ZERO_BLANK == 0) begin : g_no_lzb
        assign blank_digit[gi] = 1'b0;
      end else begin : g_lzb
        assign blank_digit[gi] = upper_zero[gi];
      end
      assign digit_seg[gi] = blank_digit[gi] ? 7'h7F : decode7(disp_value_reg[4*gi +: 4]);
      assign onehot[gi]    = (idx_reg == IDX_W'(gi));
    end
  endgenerate

  // Next pin state for the selected digit, or all dark while blanked.
  always_comb begin
    seg_next   = 7'h7F;
    dp_next    = 1'b1;
    anode_next = ANODE_IDLE;
    if (!bus.blankIn) begin
      seg_next   = digit_seg[idx_reg];
      dp_next    = ~disp_dp_reg[idx_reg];
      anode_next = (ANODE_ACTIVE_LOW != 0) ? ~onehot : onehot;
    end
  end

  // Registered pin drivers and the frame pulse following the wrap edge.
  always_ff @(posedge clkIn or negedge rstNIn) begin
    if (!rstNIn) begin
      seg_reg   <= 7'h7F;
      dp_reg    <= 1'b1;
      anode_reg <= ANODE_IDLE;
      frame_reg <= 1'b0;
    end else begin
      seg_reg   <= seg_next;
      dp_reg    <= dp_next;
      anode_reg <= anode_next;
      frame_reg <= wrap;
    end
  end

  assign bus.segOut     = seg_reg;
  assign bus.dpOut      = dp_reg;
  assign bus.anodeOut   = anode_reg;
  assign bus.frameOut   = frame_reg;
  assign bus.pendingOut = pending_reg;

endmodule

// File: tb/tb_seg_display_mux.sv
// Directed bench for seg_display_mux: two instances (leading-zero blanking
// off/on) share one stimulus stream; inputs change and outputs are sampled
// on the falling clock edge.
module tb_seg_display_mux;

  logic        clk;
  logic        rst_n;
  logic [15:0] value;
  logic [3:0]  dp;
  logic        load;
  logic        blank;

  int total = 0;
  int bad   = 0;

  seg_display_mux_if #(.NUM_DIGITS(4)) bus0 ();
  seg_display_mux_if #(.NUM_DIGITS(4)) bus1 ();

  assign bus0.valueIn = value;
  assign bus0.dpIn    = dp;
  assign bus0.loadIn  = load;
  assign bus0.blankIn = blank;
  assign bus1.valueIn = value;
  assign bus1.dpIn    = dp;
  assign bus1.loadIn  = load;
  assign bus1.blankIn = blank;

  seg_display_mux #(
    .NUM_DIGITS(4), .TICK_DIV(4), .LEAD_ZERO_BLANK(0), .ANODE_ACTIVE_LOW(1)
  ) dut0 (
    .clkIn(clk), .rstNIn(rst_n), .bus(bus0)
  );

  seg_display_mux #(
    .NUM_DIGITS(4), .TICK_DIV(4), .LEAD_ZERO_BLANK(1), .ANODE_ACTIVE_LOW(1)
  ) dut1 (
    .clkIn(clk), .rstNIn(rst_n), .bus(bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
    $display("check %-14s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Bounded wait for the frame pulse; an expired bound shows up as a failed check.
  task automatic wait_frame(input string tag);
    int n = 0;
    @(negedge clk);
    while (bus0.frameOut !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(bus0.frameOut), 32'd1);
  endtask

  logic [3:0] an_exp  [4] = '{4'hE, 4'hD, 4'hB, 4'h7};
  logic [6:0] s1234   [4] = '{7'h19, 7'h30, 7'h24, 7'h79};
  logic [6:0] sabcd   [4] = '{7'h21, 7'h46, 7'h03, 7'h08};
  logic       dp_exp  [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
  logic [6:0] lz0050  [4] = '{7'h40, 7'h12, 7'h7F, 7'h7F};
  logic [6:0] lz0000  [4] = '{7'h40, 7'h7F, 7'h7F, 7'h7F};

  initial begin
    value = '0; dp = '0; load = 1'b0; blank = 1'b0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    // Reset state before any clock edge
    chk("rst_seg",   32'(bus0.segOut),     32'h7F);
    chk("rst_dp",    32'(bus0.dpOut),      32'd1);
    chk("rst_anode", 32'(bus0.anodeOut),   32'hF);
    chk("rst_frame", 32'(bus0.frameOut),   32'd0);
    chk("rst_pend",  32'(bus0.pendingOut), 32'd0);

    @(negedge clk);
    rst_n = 1'b1;
    cyc(1);
    chk("rel_anode", 32'(bus0.anodeOut), 32'hE);
    chk("rel_seg",   32'(bus0.segOut),   32'h40);
    cyc(5);
    chk("slot1_anode", 32'(bus0.anodeOut), 32'hD);
    // Asynchronous reset mid-slot, away from any clock edge
    #2 rst_n = 1'b0;
    #1;
    chk("async_anode", 32'(bus0.anodeOut), 32'hF);
    chk("async_seg",   32'(bus0.segOut),   32'h7F);
    chk("async_dp",    32'(bus0.dpOut),    32'd1);

    // Scan of 16'h1234 over two frames
    @(negedge clk);
    rst_n = 1'b1;
    value = 16'h1234; load = 1'b1;
    cyc(1);
    load = 1'b0;
    chk("s2_pend", 32'(bus0.pendingOut), 32'd1);
    wait_frame("s2_frame0");
    chk("s2_commit", 32'(bus0.pendingOut), 32'd0);
    for (int f = 0; f < 2; f++) begin
      for (int d = 0; d < 4; d++) begin
        for (int c = 0; c < 4; c++) begin
          cyc(1);
          chk("s2_anode", 32'(bus0.anodeOut), 32'(an_exp[d]));
          chk("s2_seg",   32'(bus0.segOut),   32'(s1234[d]));
          if (!(d == 3 && c == 3)) chk("s2_noframe", 32'(bus0.frameOut), 32'd0);
        end
      end
      chk("s2_period", 32'(bus0.frameOut), 32'd1);
    end

    // Double buffer: mid-frame load stays hidden until the wrap
    cyc(6);
    value = 16'hABCD; load = 1'b1;
    cyc(1);
    load = 1'b0;
    chk("s3_pend",    32'(bus0.pendingOut), 32'd1);
    chk("s3_oldseg",  32'(bus0.segOut),     32'h30);
    cyc(8);
    chk("s3_pend15",  32'(bus0.pendingOut), 32'd1);
    chk("s3_old15",   32'(bus0.segOut),     32'h79);
    cyc(1);
    chk("s3_frame",   32'(bus0.frameOut),   32'd1);
    chk("s3_commit",  32'(bus0.pendingOut), 32'd0);
    for (int d = 0; d < 4; d++) begin
      cyc(1);
      chk("s3_seg", 32'(bus0.segOut), 32'(sabcd[d]));
      cyc(3);
    end

    // Load exactly on the wrap edge: commit waits one more frame
    cyc(15);
    value = 16'h5678; load = 1'b1;
    cyc(1);
    load = 1'b0;
    chk("s4_frame",   32'(bus0.frameOut),   32'd1);
    chk("s4_pend",    32'(bus0.pendingOut), 32'd1);
    cyc(1);
    chk("s4_oldseg",  32'(bus0.segOut),     32'h21);
    cyc(15);
    chk("s4_frame2",  32'(bus0.frameOut),   32'd1);
    chk("s4_commit",  32'(bus0.pendingOut), 32'd0);
    cyc(1);
    chk("s4_newseg",  32'(bus0.segOut),     32'h00);
    cyc(15);

    // Global blanking: dark pins, scanning and frame pulse continue
    blank = 1'b1;
    cyc(1);
    chk("s6_banode", 32'(bus0.anodeOut), 32'hF);
    chk("s6_bseg",   32'(bus0.segOut),   32'h7F);
    chk("s6_bdp",    32'(bus0.dpOut),    32'd1);
    cyc(15);
    chk("s6_bframe", 32'(bus0.frameOut), 32'd1);
    chk("s6_banode2", 32'(bus0.anodeOut), 32'hF);
    blank = 1'b0;
    dp = 4'b0100; load = 1'b1;
    cyc(1);
    load = 1'b0;
    cyc(15);
    for (int d = 0; d < 4; d++) begin
      cyc(1);
      chk("s6_anode", 32'(bus0.anodeOut), 32'(an_exp[d]));
      chk("s6_dp",    32'(bus0.dpOut),    32'(dp_exp[d]));
      cyc(3);
    end

    // Leading-zero blanking (second instance) versus none (first instance)
    value = 16'h0050; dp = 4'b1000; load = 1'b1;
    cyc(1);
    load = 1'b0;
    cyc(15);
    for (int d = 0; d < 4; d++) begin
      cyc(1);
      chk("s5_anode", 32'(bus1.anodeOut), 32'(an_exp[d]));
      chk("s5_seg",   32'(bus1.segOut),   32'(lz0050[d]));
      if (d == 3) begin
        chk("s5_blkdp",  32'(bus1.dpOut),  32'd0);
        chk("s5_nolzb",  32'(bus0.segOut), 32'h40);
      end
      cyc(3);
    end
    value = 16'h0000; dp = 4'b0000; load = 1'b1;
    cyc(1);
    load = 1'b0;
    cyc(15);
    for (int d = 0; d < 4; d++) begin
      cyc(1);
      chk("s5_zero", 32'(bus1.segOut), 32'(lz0000[d]));
      cyc(3);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
